prog_sequencer: RTL and testbench

Parametrised program sequencer with writable instruction store for CPU mode 1. Holds a program of `2**ADDR_W` words, steps a program counter through it, and presents instructions to the ALU datapath over a valid/ready handshake. Executes its own control opcodes, JMP and HALT, so programs can loop and stop without ALU involvement. Optional write port lets the host reload the program at runtime.

---
 rtl/prog_seq_pkg.sv | 21 ++
 rtl/prog_store.sv | 68 ++++++
 rtl/prog_sequencer.sv | 116 +++++++++++
 tb/tb_prog_sequencer.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_seq_pkg.sv
// prog_seq_pkg: shared definitions for the program sequencer.
//   OPC_W        opcode field width (top bits of every instruction word)
//   OPC_*        opcode encodings; JMP and HALT are executed by the sequencer,
//                all other codes are data instructions handed to the ALU
//   state_e      sequencer FSM encoding (ST_RUN is the reset state)
package prog_seq_pkg;

    localparam int OPC_W = 3;

    localparam logic [OPC_W-1:0] OPC_ADD  = 3'b000;
    localparam logic [OPC_W-1:0] OPC_SUB  = 3'b001;
    localparam logic [OPC_W-1:0] OPC_MUL  = 3'b010;
    localparam logic [OPC_W-1:0] OPC_JMP  = 3'b110;
    localparam logic [OPC_W-1:0] OPC_HALT = 3'b111;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

endpackage

// File: rtl/prog_store.sv
// prog_store: instruction store of 2**ADDR_W words holding the default program
// image (ADD 3, SUB 2, MUL 5, NOP, then zeros).
// Configuration macro: PROG_SEQ_WRITE_EN
//   defined   -> words are registers loaded with the default image and
//                rewritable through the write port
//   undefined -> constant image (ROM); write port inputs are ignored
// Ports:
//   clk_i      clock for the write port
//   wr_en_i    write strobe; rom[wr_addr_i] <= wr_data_i at the rising edge
//   wr_addr_i  write address
//   wr_data_i  write data
//   rd_addr_i  combinational read address
//   rd_data_o  word at rd_addr_i (a same-cycle write is seen one cycle later)
module prog_store
    import prog_seq_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int OPND_W = DATA_W - OPC_W;

    function automatic logic [DATA_W-1:0] default_word(input int idx);
        logic [DATA_W-1:0] w;
        w = '0;
        case (idx)
            0:       w = {OPC_ADD, OPND_W'(3)};
            1:       w = {OPC_SUB, OPND_W'(2)};
            2:       w = {OPC_MUL, OPND_W'(5)};
            default: w = '0;  // address 3 is NOP, the rest are zero
        endcase
        return w;
    endfunction

`ifdef PROG_SEQ_WRITE_EN
    logic [DATA_W-1:0] words [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        // Power-up value is the default image; reset never touches it.
        logic [DATA_W-1:0] word_q = default_word(i);

        always_ff @(posedge clk_i) begin
            if (wr_en_i && (wr_addr_i == ADDR_W'(i))) begin
                word_q <= wr_data_i;
            end
        end

        assign words[i] = word_q;
    end

    assign rd_data_o = words[rd_addr_i];
`else
    // Constant image; the write port is kept only so instantiations match.
    logic unused_wr;
    assign unused_wr = ^{clk_i, wr_en_i, wr_addr_i, wr_data_i};

    assign rd_data_o = default_word(int'(rd_addr_i));
`endif

endmodule

// File: rtl/prog_sequencer.sv
// prog_sequencer: steps a PC through the instruction store and presents data
// instructions to the ALU. JMP and HALT are executed locally and never shown
// to the ALU.
// Configuration macro: PROG_SEQ_WRITE_EN enables the store write port.
// Handshake: instr_out is offered while instr_valid is high; it is consumed
// in a cycle where instr_valid && instr_ready at the rising edge, and both
// pc and instr_out hold while instr_valid && !instr_ready.
// Ports:
//   clock, reset         single clock, synchronous active-high reset
//   ena                  advance enable; when low nothing advances
//   start                leave HALT (only together with ena)
//   instr_ready          ALU accepts instr_out
//   instr_valid          instr_out holds a data instruction
//   instr_out            rom[pc], combinational
//   pc_out               current PC
//   halted               FSM is in ST_HALT
//   wr_en/addr/data      program write port (honoured in any state and in reset)
module prog_sequencer
    import prog_seq_pkg::*;
#(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 8,
    parameter int END_ADDR = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ena,
    input  logic              start,
    input  logic              instr_ready,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic              halted,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] next_pc;
    logic [OPC_W-1:0]  opcode;
    logic [DATA_W-OPC_W-1:0] operand;
    logic              valid_raw;

    prog_store #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_store (
        .clk_i     (clock),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .rd_addr_i (pc_q),
        .rd_data_o (instr_out)
    );

    assign opcode  = instr_out[DATA_W-1 -: OPC_W];
    assign operand = instr_out[DATA_W-OPC_W-1:0];

    // Wrap at END_ADDR; the all-ones check catches a JMP past END_ADDR.
    assign next_pc = ((pc_q == ADDR_W'(END_ADDR)) || (&pc_q)) ? '0
                                                              : pc_q + ADDR_W'(1);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        valid_raw = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (ena) begin
                    case (opcode)
                        OPC_JMP: begin
                            // Operand is zero-extended or truncated to the PC.
                            pc_d = ADDR_W'(operand);
                        end
                        OPC_HALT: begin
                            state_d = ST_HALT;
                        end
                        default: begin
                            valid_raw = 1'b1;
                            if (instr_ready) begin
                                pc_d = next_pc;
                            end
                        end
                    endcase
                end
            end
            ST_HALT: begin
                if (ena && start) begin
                    pc_d    = next_pc;
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_RUN;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Nothing is offered while reset is high, so no acceptance can be counted.
    assign instr_valid = valid_raw & ~reset;
    assign pc_out      = pc_q;
    assign halted      = (state_q == ST_HALT);

endmodule

// File: tb/tb_prog_sequencer.sv
module tb_prog_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       ena;
    logic       start;
    logic       instr_ready;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       instr_valid;
    logic [7:0] instr_out;
    logic [3:0] pc_out;
    logic       halted;

    // Second instance wrapping at the all-ones address.
    logic       wide_valid;
    logic [7:0] wide_instr;
    logic [3:0] wide_pc;
    logic       wide_halted;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] img [4] = '{8'h03, 8'h22, 8'h45, 8'h00};

    prog_sequencer #(.ADDR_W(4), .DATA_W(8), .END_ADDR(3)) u_dut (
        .clock       (clock),
        .reset       (reset),
        .ena         (ena),
        .start       (start),
        .instr_ready (instr_ready),
        .instr_valid (instr_valid),
        .instr_out   (instr_out),
        .pc_out      (pc_out),
        .halted      (halted),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data)
    );

    prog_sequencer #(.ADDR_W(4), .DATA_W(8), .END_ADDR(15)) u_wide (
        .clock       (clock),
        .reset       (reset),
        .ena         (ena),
        .start       (start),
        .instr_ready (instr_ready),
        .instr_valid (wide_valid),
        .instr_out   (wide_instr),
        .pc_out      (wide_pc),
        .halted      (wide_halted),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; ena = 1'b0; start = 1'b0; instr_ready = 1'b0; wr_en = 1'b0;
        wr_addr = '0; wr_data = '0;
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic write_word(input logic [3:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; ena = 1'b1; start = 1'b1; instr_ready = 1'b1; wr_en = 1'b0;
        wr_addr = '0; wr_data = '0;
        tick(); tick();
        n_checks++;
        if (pc_out !== 4'd0) begin n_errors++; $display("FAIL reset_pc: got %0d expected 0", pc_out); end
        n_checks++;
        if (halted !== 1'b0) begin n_errors++; $display("FAIL reset_halted: got %b expected 0", halted); end
        n_checks++;
        if (instr_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
        n_checks++;
        if (instr_out !== 8'h03) begin n_errors++; $display("FAIL reset_instr: got %h expected 03", instr_out); end
        reset = 1'b0; ena = 1'b0; start = 1'b0;
        #1;
        n_checks++;
        if (instr_valid !== 1'b0) begin n_errors++; $display("FAIL idle_valid: got %b expected 0", instr_valid); end
        ena = 1'b1;
        #1;
        n_checks++;
        if (instr_valid !== 1'b1) begin n_errors++; $display("FAIL ena_valid: got %b expected 1", instr_valid); end
        ena = 1'b0;
        #1;
    endtask

    task automatic test_sequence();
        do_reset();
        ena = 1'b1; instr_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            n_checks++;
            if (instr_out !== img[k % 4] || pc_out !== 4'(k % 4) || instr_valid !== 1'b1) begin
                n_errors++;
                $display("FAIL seq[%0d]: got instr=%h pc=%0d valid=%b expected instr=%h pc=%0d valid=1",
                         k, instr_out, pc_out, instr_valid, img[k % 4], k % 4);
            end
            tick();
        end
        ena = 1'b0;
    endtask

    task automatic test_stall();
        do_reset();
        ena = 1'b1; instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++;
            if (pc_out !== 4'd1 || instr_out !== 8'h22 || instr_valid !== 1'b1) begin
                n_errors++;
                $display("FAIL stall[%0d]: got pc=%0d instr=%h valid=%b expected pc=1 instr=22 valid=1",
                         k, pc_out, instr_out, instr_valid);
            end
            tick();
        end
        instr_ready = 1'b1;
        #1;
        n_checks++;
        if (pc_out !== 4'd1) begin n_errors++; $display("FAIL stall_release: got pc=%0d expected 1", pc_out); end
        tick();
        n_checks++;
        if (pc_out !== 4'd2 || instr_out !== 8'h45) begin
            n_errors++;
            $display("FAIL stall_advance: got pc=%0d instr=%h expected pc=2 instr=45", pc_out, instr_out);
        end
        ena = 1'b0;
    endtask

    task automatic test_ena_toggle();
        logic [3:0] exp_pc;
        logic       pat [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        do_reset();
        instr_ready = 1'b1;
        exp_pc = 4'd0;
        for (int k = 0; k < 6; k++) begin
            ena = pat[k];
            #1;
            n_checks++;
            if (pc_out !== exp_pc || instr_valid !== pat[k] || instr_out !== img[exp_pc[1:0]]) begin
                n_errors++;
                $display("FAIL ena_toggle[%0d]: got pc=%0d valid=%b instr=%h expected pc=%0d valid=%b instr=%h",
                         k, pc_out, instr_valid, instr_out, exp_pc, pat[k], img[exp_pc[1:0]]);
            end
            tick();
            if (pat[k]) exp_pc = (exp_pc == 4'd3) ? 4'd0 : exp_pc + 4'd1;
        end
        ena = 1'b0;
        #1;
        n_checks++;
        if (pc_out !== exp_pc) begin n_errors++; $display("FAIL ena_final: got pc=%0d expected %0d", pc_out, exp_pc); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        ena = 1'b1; instr_ready = 1'b1;
        tick(); tick();
        instr_ready = 1'b0;
        #1;
        n_checks++;
        if (pc_out !== 4'd2 || instr_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL mid_pre: got pc=%0d valid=%b expected pc=2 valid=1", pc_out, instr_valid);
        end
        reset = 1'b1; instr_ready = 1'b1;
        #1;
        n_checks++;
        if (instr_valid !== 1'b0) begin n_errors++; $display("FAIL mid_valid: got %b expected 0", instr_valid); end
        tick();
        reset = 1'b0; ena = 1'b0;
        #1;
        n_checks++;
        if (pc_out !== 4'd0 || halted !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_post: got pc=%0d halted=%b expected pc=0 halted=0", pc_out, halted);
        end
        ena = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_checks++;
            if (instr_out !== img[k]) begin
                n_errors++;
                $display("FAIL mid_store[%0d]: got %h expected %h", k, instr_out, img[k]);
            end
            tick();
        end
        ena = 1'b0;
    endtask

    task automatic test_wrap_all_ones();
        logic [7:0] exp_w;
        do_reset();
        ena = 1'b1; instr_ready = 1'b1;
        for (int k = 0; k < 18; k++) begin
            exp_w = ((k % 16) < 4) ? img[k % 4] : 8'h00;
            #1;
            n_checks++;
            if (wide_pc !== 4'(k % 16) || wide_instr !== exp_w || wide_valid !== 1'b1 || wide_halted !== 1'b0) begin
                n_errors++;
                $display("FAIL wrap[%0d]: got pc=%0d instr=%h valid=%b halted=%b expected pc=%0d instr=%h valid=1 halted=0",
                         k, wide_pc, wide_instr, wide_valid, wide_halted, k % 16, exp_w);
            end
            tick();
        end
        ena = 1'b0;
    endtask

`ifdef PROG_SEQ_WRITE_EN
    task automatic test_write_visibility();
        do_reset();
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'h07;
        #1;
        n_checks++;
        if (instr_out !== 8'h03) begin n_errors++; $display("FAIL wr_same_cycle: got %h expected 03", instr_out); end
        tick();
        wr_en = 1'b0;
        #1;
        n_checks++;
        if (instr_out !== 8'h07) begin n_errors++; $display("FAIL wr_next_cycle: got %h expected 07", instr_out); end
        write_word(4'd0, 8'h03);
        n_checks++;
        if (instr_out !== 8'h03) begin n_errors++; $display("FAIL wr_restore: got %h expected 03", instr_out); end
    endtask

    task automatic test_jmp();
        logic [3:0] seq0 [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0, 4'd1, 4'd2, 4'd3};
        logic [3:0] seq1 [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd1, 4'd2, 4'd3, 4'd1};
        logic [3:0] ep;
        logic [7:0] ei;
        for (int t = 0; t < 2; t++) begin
            do_reset();
            write_word(4'd3, (t == 0) ? 8'hC0 : 8'hC1);
            ena = 1'b1; instr_ready = 1'b1;
            for (int k = 0; k < 8; k++) begin
                ep = (t == 0) ? seq0[k] : seq1[k];
                ei = (ep == 4'd3) ? ((t == 0) ? 8'hC0 : 8'hC1) : img[ep[1:0]];
                #1;
                n_checks++;
                if (pc_out !== ep || instr_out !== ei || instr_valid !== (ep != 4'd3)) begin
                    n_errors++;
                    $display("FAIL jmp%0d[%0d]: got pc=%0d instr=%h valid=%b expected pc=%0d instr=%h valid=%b",
                             t, k, pc_out, instr_out, instr_valid, ep, ei, ep != 4'd3);
                end
                tick();
            end
            ena = 1'b0;
        end
        write_word(4'd3, 8'h00);
    endtask

    task automatic test_halt();
        do_reset();
        write_word(4'd2, 8'hE0);
        ena = 1'b1; instr_ready = 1'b1;
        tick(); tick();
        n_checks++;
        if (pc_out !== 4'd2 || instr_valid !== 1'b0 || halted !== 1'b0) begin
            n_errors++;
            $display("FAIL halt_fetch: got pc=%0d valid=%b halted=%b expected pc=2 valid=0 halted=0",
                     pc_out, instr_valid, halted);
        end
        tick();
        for (int k = 0; k < 10; k++) begin
            n_checks++;
            if (pc_out !== 4'd2 || instr_valid !== 1'b0 || halted !== 1'b1) begin
                n_errors++;
                $display("FAIL halt_hold[%0d]: got pc=%0d valid=%b halted=%b expected pc=2 valid=0 halted=1",
                         k, pc_out, instr_valid, halted);
            end
            tick();
        end
        ena = 1'b0; start = 1'b1;
        tick(); tick();
        n_checks++;
        if (pc_out !== 4'd2 || halted !== 1'b1) begin
            n_errors++;
            $display("FAIL halt_start_no_ena: got pc=%0d halted=%b expected pc=2 halted=1", pc_out, halted);
        end
        ena = 1'b1;
        tick();
        start = 1'b0; ena = 1'b0;
        #1;
        n_checks++;
        if (pc_out !== 4'd3 || halted !== 1'b0 || instr_out !== 8'h00) begin
            n_errors++;
            $display("FAIL halt_resume: got pc=%0d halted=%b instr=%h expected pc=3 halted=0 instr=00",
                     pc_out, halted, instr_out);
        end
        write_word(4'd2, 8'h45);
    endtask
`else
    task automatic test_write_ignored();
        do_reset();
        write_word(4'd0, 8'hC3);
        write_word(4'd1, 8'hE0);
        write_word(4'd2, 8'hFF);
        write_word(4'd3, 8'h11);
        ena = 1'b1; instr_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_checks++;
            if (instr_out !== img[k % 4] || pc_out !== 4'(k % 4) || halted !== 1'b0) begin
                n_errors++;
                $display("FAIL rom_ignore[%0d]: got instr=%h pc=%0d halted=%b expected instr=%h pc=%0d halted=0",
                         k, instr_out, pc_out, halted, img[k % 4], k % 4);
            end
            tick();
        end
        ena = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_sequence();
        test_stall();
        test_ena_toggle();
        test_reset_mid();
        test_wrap_all_ones();
`ifdef PROG_SEQ_WRITE_EN
        test_write_visibility();
        test_jmp();
        test_halt();
`else
        test_write_ignored();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
